sprite_control: RTL
===================

# sprite_control

Upstream companion of the 8x8-upscaled sprite row stage. It owns the sprite bitmap shift register, serially loads it from a streaming source, latches the sprite position once per frame, and derives the per-pixel strobes `new_line`, `sprite_access` and `sprite_visible` from the 800x600 pixel counters. The downstream row stage consumes `sprite_data` and returns `sprite_shift` whenever it needs the next bitmap bit.

## Interface
Parameters:
- `WIDTH`, 8, sprite width in coarse (8x8) pixels, 2..16
- `HEIGHT`, 8, sprite height in coarse pixels, 1..16
- `X_MAX`, 100, coarse screen width
- `Y_MAX`, 75, coarse screen height

Ports:
- `clk`  in  1  pixel clock, one pixel per cycle
- `reset`  in  1  asynchronous, active-high reset
- `counter_h`  in  10  current pixel column (blanking included)
- `counter_v`  in  10  current pixel row (blanking included)
- `pos_x`  in  7  requested coarse sprite x
- `pos_y`  in  7  requested coarse sprite y
- `load_start`  in  1  pulse: begin a bitmap reload
- `load_valid`  in  1  `load_data` is valid
- `load_data`  in  1  bitmap bit, row-major, MSB of row first
- `load_ready`  out  1  high in LOADING; a bit is taken when `load_valid && load_ready`
- `sprite_data`  out  1  MSB of the bitmap register
- `sprite_shift`  in  1  rotate the bitmap register by one
- `new_line`  out  1  `counter_v[2:0] == 0`
- `sprite_access`  out  1  `counter_h[2:0] == 7` (last pixel of a coarse pixel)
- `sprite_visible`  out  1  current coarse position lies inside the sprite and state is SHOW
- `sprite_wrap`  out  1  one-cycle pulse when the shift count wraps
- `misalign`  out  1  sticky error flag

## Operation
- Bitmap register is `WIDTH*HEIGHT` bits. `sprite_shift` rotates it left (MSB re-enters at LSB). In LOADING, an accepted bit shifts in at LSB. `sprite_shift` is ignored outside SHOW.
- Shift counter (`$clog2(WIDTH*HEIGHT)` bits) counts `sprite_shift` in SHOW. At `WIDTH*HEIGHT-1` it wraps to 0 and pulses `sprite_wrap` in the same cycle as the shift.
- Frame start means `counter_h == 0 && counter_v == 0`.
- At frame start, `pos_x`/`pos_y` are clamped to `X_MAX-WIDTH` / `Y_MAX-HEIGHT` and latched into `x_q`/`y_q`. The latched position is constant for the whole frame.
- Coarse coordinates: `cx = counter_h[9:3]`, `cy = counter_v[9:3]`.
- `sprite_visible = (state==SHOW) && x_q <= cx < x_q+WIDTH && y_q <= cy < y_q+HEIGHT`. Use 8-bit compares so there is no overflow.
- FSM states:
  - IDLE (reset state): go to LOADING on `load_start`.
  - LOADING: accept bits. After the `WIDTH*HEIGHT`-th accepted bit, go to ARMED. A new `load_start` here restarts the bit count.
  - ARMED: go to SHOW at the next frame start. The shift counter clears on that transition.
  - SHOW: go to LOADING on `load_start`; the bit count clears.
- `misalign` is set if a frame start occurs in SHOW, not on the ARMED→SHOW transition, with shift counter ≠ 0. It is cleared only by reset.
- `load_start` has priority over a same-cycle accepted bit or frame start.

## Timing
- Reset values: state IDLE, bitmap 0, `x_q`/`y_q` 0, counters 0, `load_ready` 0, `sprite_visible` 0, `sprite_wrap` 0, `misalign` 0, `sprite_data` 0.
- Reset asserted mid-load or mid-frame aborts immediately. No partial bitmap is retained as valid.
- `new_line`, `sprite_access`, `sprite_visible`, `sprite_data` and `load_ready` are combinational from counters and registers, with zero latency. This lets the downstream stage shift at the edge that ends the coarse pixel.
- Register and state updates take effect on the rising edge following the qualifying inputs.
- LOADING with `load_valid` held high takes exactly `WIDTH*HEIGHT` cycles to reach ARMED.
- Each visible frame consumes exactly `WIDTH*HEIGHT` shifts: `WIDTH` per coarse row × `HEIGHT` rows, issued only on `new_line` rows. This leaves the register realigned at frame end.

## Test plan
- Reset mid-LOADING after 10 bits → `load_ready`=0, `sprite_visible`=0, `sprite_data`=0, `misalign`=0 on the next cycle.
- Load an 8x8 checkerboard with `load_valid` held high → ARMED after 64 cycles; at frame start `sprite_data`=1 (first bit) and state is SHOW.
- `pos_x`=10, `pos_y`=5 → `sprite_visible` high exactly for `counter_h` 80..143 on `counter_v` 40..103. `sprite_access` is high at `counter_h` 87, 95, … 143.
- Run 2 frames with a model of the downstream stage → 64 shifts per frame, `sprite_wrap` once per frame, `misalign` stays 0, bitmap unchanged.
- `pos_x`=120, `pos_y`=90 → clamped to 92/67; the sprite occupies coarse 92..99 × 67..74.
- Inject one extra `sprite_shift` in SHOW → `misalign`=1 at the next frame start and stays set through a subsequent reload.

Source files
------------

// File: rtl/sprite_control.sv
// Sprite bitmap owner: serial bitmap load, per-frame position latch, and the
// per-pixel strobes consumed by the downstream 8x8-upscaled sprite row stage.
module sprite_control #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int X_MAX  = 100,
  parameter int Y_MAX  = 75
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] counter_h,
  input  logic [9:0] counter_v,
  input  logic [6:0] pos_x,
  input  logic [6:0] pos_y,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic       load_data,
  output logic       load_ready,
  output logic       sprite_data,
  input  logic       sprite_shift,
  output logic       new_line,
  output logic       sprite_access,
  output logic       sprite_visible,
  output logic       sprite_wrap,
  output logic       misalign
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int CW = $clog2(N);
  localparam logic [6:0] X_LIM = 7'(X_MAX - WIDTH);
  localparam logic [6:0] Y_LIM = 7'(Y_MAX - HEIGHT);

  typedef enum logic [1:0] {IDLE, LOADING, ARMED, SHOW} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    bitmap_q, bitmap_d;
  logic [CW-1:0]   load_cnt_q, load_cnt_d;
  logic [CW-1:0]   shift_cnt_q, shift_cnt_d;
  logic [6:0]      x_q, x_d, y_q, y_d;
  logic            misalign_q, misalign_d;

  logic            frame_start;
  logic            take_bit;
  logic            shift_en;
  logic [7:0]      cx, cy, x_end, y_end;

  assign frame_start = (counter_h == 10'd0) && (counter_v == 10'd0);
  assign take_bit    = (state_q == LOADING) && load_valid && !load_start;
  assign shift_en    = (state_q == SHOW) && sprite_shift && !load_start;

  // 8-bit coarse compares keep x_q+WIDTH from overflowing at the right edge.
  assign cx    = {1'b0, counter_h[9:3]};
  assign cy    = {1'b0, counter_v[9:3]};
  assign x_end = {1'b0, x_q} + 8'(WIDTH);
  assign y_end = {1'b0, y_q} + 8'(HEIGHT);

  assign load_ready     = (state_q == LOADING);
  assign sprite_data    = bitmap_q[N-1];
  assign new_line       = (counter_v[2:0] == 3'd0);
  assign sprite_access  = (counter_h[2:0] == 3'd7);
  assign sprite_visible = (state_q == SHOW) &&
                          (cx >= {1'b0, x_q}) && (cx < x_end) &&
                          (cy >= {1'b0, y_q}) && (cy < y_end);
  assign sprite_wrap    = shift_en && (shift_cnt_q == CW'(N - 1));
  assign misalign       = misalign_q;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case
    // can leave a signal unassigned and infer a latch.
    state_d     = state_q;
    bitmap_d    = bitmap_q;
    load_cnt_d  = load_cnt_q;
    shift_cnt_d = shift_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    misalign_d  = misalign_q;

    if (frame_start) begin
      x_d = (pos_x > X_LIM) ? X_LIM : pos_x;
      y_d = (pos_y > Y_LIM) ? Y_LIM : pos_y;
    end

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d    = LOADING;
          load_cnt_d = '0;
        end
      end
      LOADING: begin
        if (load_start) begin
          load_cnt_d = '0;
        end else if (take_bit) begin
          bitmap_d = {bitmap_q[N-2:0], load_data};
          if (load_cnt_q == CW'(N - 1)) begin
            state_d    = ARMED;
            load_cnt_d = '0;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      ARMED: begin
        if (load_start) begin
          state_d    = LOADING;
          load_cnt_d = '0;
        end else if (frame_start) begin
          state_d     = SHOW;
          shift_cnt_d = '0;
        end
      end
      SHOW: begin
        if (load_start) begin
          state_d    = LOADING;
          load_cnt_d = '0;
        end else begin
          if (shift_en) begin
            bitmap_d    = {bitmap_q[N-2:0], bitmap_q[N-1]};
            shift_cnt_d = sprite_wrap ? '0 : shift_cnt_q + 1'b1;
          end
          // A frame that ends mid-bitmap means the consumer lost alignment.
          if (frame_start && (shift_cnt_q != '0)) misalign_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      // NOTE: the bitmap is cleared on reset so an aborted load never
      // survives as displayable data.
      bitmap_q    <= '0;
      load_cnt_q  <= '0;
      shift_cnt_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      misalign_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      bitmap_q    <= bitmap_d;
      load_cnt_q  <= load_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      misalign_q  <= misalign_d;
    end
  end

endmodule
